// File: rtl/furv_bus_pkg.sv
// furv_bus_pkg: shared types and widths for the furv Wishbone bridges.
package furv_bus_pkg;
  localparam int WB_ADDR_W = 30;
  localparam int WB_SEL_W  = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/furv_bus_timeout.sv
// furv_bus_timeout: cycle counter that flags expiry after TIMEOUT counted cycles.
module furv_bus_timeout #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic en_i,
  output logic expired_o
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = start_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  // TIMEOUT of zero means wait forever
  assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);
endmodule

// File: rtl/furv_dbus_bridge.sv
// furv_dbus_bridge: furv core data port to Wishbone B4 classic single-transfer master,
// with bus timeout and a sticky error record.
module furv_dbus_bridge
  import furv_bus_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_mem,
  input  logic                 core_mem_write,
  input  logic [WB_ADDR_W-1:0] core_addr,
  input  logic [WB_SEL_W-1:0]  core_sel,
  input  logic [31:0]          core_data_out,
  output logic [31:0]          core_data_in,
  output logic                 core_ack,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_ADDR_W-1:0] wb_adr_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  output logic                 bus_error,
  output logic [WB_ADDR_W-1:0] err_addr,
  input  logic                 err_clr
);
  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d, we_q, we_d, ack_q, ack_d, berr_q, berr_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d, eaddr_q, eaddr_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic [31:0]          dat_q, dat_d, rdat_q, rdat_d;
  logic                 tmo_start, tmo_en, expired, fault;

  furv_bus_timeout #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .start_i   (tmo_start),
    .en_i      (tmo_en),
    .expired_o (expired)
  );

  // a late ack on the expiry cycle still counts as success
  assign fault = wb_err_i || (!wb_ack_i && expired);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    berr_d    = berr_q && !err_clr;
    eaddr_d   = eaddr_q;
    tmo_start = 1'b0;
    tmo_en    = 1'b0;
    case (state_q)
      IDLE: if (core_mem) begin
        cyc_d     = 1'b1;
        we_d      = core_mem_write;
        adr_d     = core_addr;
        sel_d     = core_sel;
        dat_d     = core_data_out;
        tmo_start = 1'b1;
        state_d   = BUS;
      end
      BUS: if (wb_ack_i || fault) begin
        cyc_d   = 1'b0;
        ack_d   = 1'b1;
        rdat_d  = (fault || we_q) ? '0 : wb_dat_i;
        berr_d  = berr_d || fault;
        eaddr_d = (fault && (!berr_q || err_clr)) ? adr_q : eaddr_q;
        state_d = RESP;
      end else tmo_en = 1'b1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      berr_q  <= berr_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;
  assign core_data_in = rdat_q;
  assign core_ack     = ack_q;
  assign bus_error    = berr_q;
  assign err_addr     = eaddr_q;
endmodule

// File: tb/tb_furv_dbus_bridge.sv
// tb_furv_dbus_bridge: directed self-checking bench for furv_dbus_bridge with TIMEOUT=4.
module tb_furv_dbus_bridge;
  logic        clk = 0, rst = 1;
  logic        core_mem = 0, core_mem_write = 0, core_ack;
  logic [29:0] core_addr = '0, wb_adr_o, err_addr;
  logic [3:0]  core_sel = '0, wb_sel_o;
  logic [31:0] core_data_out = '0, core_data_in, wb_dat_o, wb_dat_i = '0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 0, wb_err_i = 0;
  logic        bus_error, err_clr = 0;
  int          checks = 0, fails = 0;

  furv_dbus_bridge #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .core_mem(core_mem), .core_mem_write(core_mem_write),
    .core_addr(core_addr), .core_sel(core_sel), .core_data_out(core_data_out),
    .core_data_in(core_data_in), .core_ack(core_ack), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_error(bus_error), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [29:0] a, input logic [3:0] s, input logic [31:0] d);
    core_mem = 1; core_mem_write = we; core_addr = a; core_sel = s; core_data_out = d;
    tick();
    core_mem = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin fails++; $display("FAIL reset_cyc_stb: got %b%b expected 00", wb_cyc_o, wb_stb_o); end
    checks++; if (core_ack !== 1'b0 || core_data_in !== 32'h0) begin fails++; $display("FAIL reset_core: got ack=%b data=%h expected 0/0", core_ack, core_data_in); end
    checks++; if (bus_error !== 1'b0 || err_addr !== 30'h0 || wb_adr_o !== 30'h0) begin fails++; $display("FAIL reset_err: got be=%b ea=%h adr=%h expected 0", bus_error, err_addr, wb_adr_o); end
    rst = 0;
  endtask

  task automatic test_load();
    request(0, 30'h4, 4'hF, 32'h0);
    checks++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 30'h4 || wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) begin fails++; $display("FAIL load_stb: got stb=%b adr=%h we=%b sel=%h expected 1/4/0/f", wb_stb_o, wb_adr_o, wb_we_o, wb_sel_o); end
    checks++; if (core_ack !== 1'b0) begin fails++; $display("FAIL load_early_ack: got %b expected 0", core_ack); end
    wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
    tick();
    wb_ack_i = 0; wb_dat_i = 32'h0;
    checks++; if (core_ack !== 1'b1 || core_data_in !== 32'hDEADBEEF) begin fails++; $display("FAIL load_ack: got ack=%b data=%h expected 1/deadbeef", core_ack, core_data_in); end
    checks++; if (wb_cyc_o !== 1'b0) begin fails++; $display("FAIL load_cyc_drop: got %b expected 0", wb_cyc_o); end
    tick();
    checks++; if (core_ack !== 1'b0 || core_data_in !== 32'hDEADBEEF) begin fails++; $display("FAIL load_pulse: got ack=%b data=%h expected 0/deadbeef", core_ack, core_data_in); end
  endtask

  task automatic test_store_wait();
    int bad = 0;
    request(1, 30'h10, 4'b0011, 32'h0000_1234);
    core_addr = 30'h3FF; core_sel = 4'hF; core_data_out = 32'hFFFF_FFFF; core_mem_write = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_stb_o !== 1'b1 || wb_dat_o !== 32'h1234 || wb_sel_o !== 4'b0011 || wb_adr_o !== 30'h10 || wb_we_o !== 1'b1 || core_ack !== 1'b0) bad++;
      if (i == 3) wb_ack_i = 1;
      tick();
    end
    wb_ack_i = 0;
    checks++; if (bad !== 0) begin fails++; $display("FAIL store_hold: got %0d unstable cycles expected 0", bad); end
    checks++; if (core_ack !== 1'b1 || wb_cyc_o !== 1'b0 || core_data_in !== 32'h0) begin fails++; $display("FAIL store_ack: got ack=%b cyc=%b data=%h expected 1/0/0", core_ack, wb_cyc_o, core_data_in); end
    checks++; if (bus_error !== 1'b0) begin fails++; $display("FAIL ack_on_expiry: got bus_error=%b expected 0", bus_error); end
    tick();
  endtask

  task automatic test_back_to_back();
    int xfers = 0, nacks = 0;
    int ack_at[4];
    logic [31:0] ack_dat[4];
    core_mem = 1; core_mem_write = 0; core_addr = 30'h20; core_sel = 4'hF;
    tick();
    for (int c = 0; c < 8; c++) begin
      wb_ack_i = wb_stb_o;
      wb_dat_i = 32'hA000 + c;
      if (wb_stb_o) xfers++;
      if (core_ack && nacks < 4) begin ack_at[nacks] = c; ack_dat[nacks] = core_data_in; nacks++; end
      if (c == 3) core_mem = 0;
      tick();
    end
    wb_ack_i = 0;
    checks++; if (xfers !== 2 || nacks !== 2) begin fails++; $display("FAIL b2b_count: got xfers=%0d acks=%0d expected 2/2", xfers, nacks); end
    if (nacks == 2) begin
      checks++; if (ack_at[1] - ack_at[0] !== 3 || ack_at[0] !== 1) begin fails++; $display("FAIL b2b_spacing: got acks at %0d,%0d expected 1,4", ack_at[0], ack_at[1]); end
      checks++; if (ack_dat[0] !== 32'hA000 || ack_dat[1] !== 32'hA003) begin fails++; $display("FAIL b2b_data: got %h,%h expected a000,a003", ack_dat[0], ack_dat[1]); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    request(0, 30'h55, 4'hF, 32'h0);
    while (wb_stb_o && n < 10) begin n++; tick(); end
    checks++; if (n !== 4) begin fails++; $display("FAIL timeout_len: got %0d stb cycles expected 4", n); end
    checks++; if (core_ack !== 1'b1 || core_data_in !== 32'h0) begin fails++; $display("FAIL timeout_resp: got ack=%b data=%h expected 1/0", core_ack, core_data_in); end
    checks++; if (bus_error !== 1'b1 || err_addr !== 30'h55) begin fails++; $display("FAIL timeout_err: got be=%b ea=%h expected 1/55", bus_error, err_addr); end
    tick();
    request(0, 30'h66, 4'hF, 32'h0);
    n = 0;
    while (wb_stb_o && n < 10) begin n++; tick(); end
    checks++; if (core_ack !== 1'b1 || bus_error !== 1'b1 || err_addr !== 30'h55) begin fails++; $display("FAIL timeout_sticky: got ack=%b be=%b ea=%h expected 1/1/55", core_ack, bus_error, err_addr); end
    tick();
    err_clr = 1; tick(); err_clr = 0;
    checks++; if (bus_error !== 1'b0) begin fails++; $display("FAIL err_clr: got %b expected 0", bus_error); end
  endtask

  task automatic test_err_ack();
    request(0, 30'h77, 4'hF, 32'h0);
    wb_ack_i = 1; wb_err_i = 1; wb_dat_i = 32'h1234_5678;
    tick();
    wb_ack_i = 0; wb_err_i = 0;
    checks++; if (core_ack !== 1'b1 || core_data_in !== 32'h0) begin fails++; $display("FAIL err_ack_resp: got ack=%b data=%h expected 1/0", core_ack, core_data_in); end
    checks++; if (bus_error !== 1'b1 || err_addr !== 30'h77) begin fails++; $display("FAIL err_ack_rec: got be=%b ea=%h expected 1/77", bus_error, err_addr); end
    tick();
    request(0, 30'h88, 4'hF, 32'h0);
    wb_err_i = 1; err_clr = 1;
    tick();
    wb_err_i = 0; err_clr = 0;
    checks++; if (bus_error !== 1'b1 || err_addr !== 30'h88) begin fails++; $display("FAIL clr_vs_set: got be=%b ea=%h expected 1/88", bus_error, err_addr); end
    tick();
    err_clr = 1; tick(); err_clr = 0;
  endtask

  task automatic test_reset_mid();
    request(1, 30'h99, 4'hF, 32'hAAAA_5555);
    tick();
    checks++; if (wb_stb_o !== 1'b1) begin fails++; $display("FAIL mid_stb: got %b expected 1", wb_stb_o); end
    rst = 1; wb_ack_i = 1;
    tick();
    rst = 0; wb_ack_i = 0;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || core_ack !== 1'b0) begin fails++; $display("FAIL mid_reset: got cyc=%b stb=%b ack=%b expected 0/0/0", wb_cyc_o, wb_stb_o, core_ack); end
    tick();
    checks++; if (wb_cyc_o !== 1'b0 || core_ack !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got cyc=%b ack=%b expected 0/0", wb_cyc_o, core_ack); end
    request(0, 30'hAB, 4'h1, 32'h0);
    checks++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 30'hAB || wb_we_o !== 1'b0) begin fails++; $display("FAIL post_reset_req: got stb=%b adr=%h we=%b expected 1/ab/0", wb_stb_o, wb_adr_o, wb_we_o); end
    wb_ack_i = 1; wb_dat_i = 32'h5A5A_5A5A;
    tick();
    wb_ack_i = 0;
    checks++; if (core_ack !== 1'b1 || core_data_in !== 32'h5A5A_5A5A) begin fails++; $display("FAIL post_reset_ack: got ack=%b data=%h expected 1/5a5a5a5a", core_ack, core_data_in); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_err_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
